mem_arbiter: RTL and testbench

// Shares the single external memory port between D-cache and I-cache line fills/writebacks.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_beat_ctr.sv | 36 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the D/I-cache memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // Requester indices; also the bit positions in the one-hot grant.
    localparam logic REQ_D = 1'b0;
    localparam logic REQ_I = 1'b1;

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Beat index counter for one burst; wraps naturally because the line length is a power of two.
module mem_arb_beat_ctr #(
    parameter int BEAT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [BEAT_W-1:0] cnt_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between D-cache and I-cache bursts.
// Each grant runs exactly one LINE_WORDS-beat burst, then a one-cycle DONE handshake.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int LINE_WORDS = 4,
    localparam int BEAT_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [1:0]        gnt_o,
    output logic [BEAT_W-1:0] beat_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              d_rvalid_o,
    output logic              i_rvalid_o,
    output logic [BEAT_W-1:0] rbeat_o,
    output logic              d_done_o,
    output logic              i_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int LINE_LSB = BEAT_W + 2;

    arb_state_e state_q, state_d;

    logic                       owner_q, owner_d;
    logic                       we_q, we_d;
    logic [ADDR_W-1:LINE_LSB]   line_q, line_d;
    logic                       last_gnt_q, last_gnt_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic [BEAT_W-1:0]          rbeat_q, rbeat_d;
    logic                       d_rvalid_q, d_rvalid_d;
    logic                       i_rvalid_q, i_rvalid_d;

    logic                       any_req;
    logic                       pick_i;
    logic                       beat_en;
    logic                       beat_clr;
    logic                       last_beat;
    logic [BEAT_W-1:0]          beat;

    // Word-offset bits of the request addresses are replaced by the beat index.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{d_addr_i[LINE_LSB-1:0], i_addr_i[LINE_LSB-1:0]};

    assign any_req  = d_req_i | i_req_i;
    assign beat_en  = (state_q == BURST) && mem_ack_i;
    assign beat_clr = (state_q != BURST);

    mem_arb_beat_ctr #(
        .BEAT_W (BEAT_W)
    ) u_beat_ctr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (beat_clr),
        .en_i    (beat_en),
        .cnt_o   (beat),
        .last_o  (last_beat)
    );

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        pick_i = i_req_i;
        if (d_req_i && i_req_i) begin
            pick_i = (last_gnt_q == REQ_D);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            owner_q    <= REQ_D;
            we_q       <= 1'b0;
            line_q     <= '0;
            last_gnt_q <= REQ_I;
            rdata_q    <= '0;
            rbeat_q    <= '0;
            d_rvalid_q <= 1'b0;
            i_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            line_q     <= line_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
            rbeat_q    <= rbeat_d;
            d_rvalid_q <= d_rvalid_d;
            i_rvalid_q <= i_rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BURST;
            BURST:   if (beat_en && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request-side values are captured only at IDLE exit; later changes are ignored.
    always_comb begin
        owner_d    = owner_q;
        we_d       = we_q;
        line_d     = line_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
        rbeat_d    = rbeat_q;
        d_rvalid_d = 1'b0;
        i_rvalid_d = 1'b0;
        if (state_q == IDLE && any_req) begin
            owner_d = pick_i ? REQ_I : REQ_D;
            we_d    = pick_i ? 1'b0 : d_we_i;
            line_d  = pick_i ? i_addr_i[ADDR_W-1:LINE_LSB] : d_addr_i[ADDR_W-1:LINE_LSB];
        end
        if (beat_en && !we_q) begin
            rdata_d    = mem_rdata_i;
            rbeat_d    = beat;
            d_rvalid_d = (owner_q == REQ_D);
            i_rvalid_d = (owner_q == REQ_I);
        end
        if (state_q == DONE) begin
            last_gnt_d = owner_q;
        end
    end

    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        d_done_o    = 1'b0;
        i_done_o    = 1'b0;
        mem_wdata_o = '0;
        if (state_q != IDLE) begin
            gnt_o[owner_q] = 1'b1;
            if (owner_q == REQ_D && we_q) begin
                mem_wdata_o = d_wdata_i;
            end
        end
        if (state_q == BURST) begin
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
        end
        if (state_q == DONE) begin
            d_done_o = (owner_q == REQ_D);
            i_done_o = (owner_q == REQ_I);
        end
    end

    assign beat_o     = beat;
    assign rdata_o    = rdata_q;
    assign rbeat_o    = rbeat_q;
    assign d_rvalid_o = d_rvalid_q;
    assign i_rvalid_o = i_rvalid_q;
    assign mem_addr_o = {line_q, beat, 2'b00};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory accesses, read returns and burst completions.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int BW = 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          d_req_i, d_we_i, i_req_i, mem_ack_i;
    logic [AW-1:0] d_addr_i, i_addr_i, mem_addr_o;
    logic [DW-1:0] d_wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]    gnt_o;
    logic [BW-1:0] beat_o, rbeat_o;
    logic          d_rvalid_o, i_rvalid_o, d_done_o, i_done_o, mem_req_o, mem_we_o;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } acc_t;
    typedef struct { bit owner; logic [31:0] data; logic [1:0] beat; } rd_t;
    typedef struct { bit owner; bit we; } done_t;

    acc_t  exp_acc[$];
    rd_t   exp_rd[$];
    done_t exp_done[$];

    int n_vec = 0;
    int n_err = 0;
    int ack_mode = 0;
    int n_txn = 0;

    always #5 clk_i = ~clk_i;

    // Writeback data and memory read data are pure functions of beat / address.
    assign d_wdata_i   = 32'hD000_0000 | 32'(beat_o);
    assign mem_rdata_i = mem_addr_o ^ 32'hC3C3_A5A5;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i),
        .gnt_o(gnt_o), .beat_o(beat_o), .rdata_o(rdata_o),
        .d_rvalid_o(d_rvalid_o), .i_rvalid_o(i_rvalid_o), .rbeat_o(rbeat_o),
        .d_done_o(d_done_o), .i_done_o(i_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input bit owner, input bit we, input logic [31:0] line);
        for (int k = 0; k < LW; k++) begin
            acc_t a;
            rd_t  r;
            a.addr  = {line[31:4], 4'(k * 4)};
            a.we    = we;
            a.wdata = we ? (32'hD000_0000 | 32'(k)) : 32'h0;
            exp_acc.push_back(a);
            if (!we) begin
                r.owner = owner;
                r.data  = a.addr ^ 32'hC3C3_A5A5;
                r.beat  = 2'(k);
                exp_rd.push_back(r);
            end
        end
        exp_done.push_back('{owner: owner, we: we});
    endtask

    task automatic start_burst(input bit owner, input bit we, input logic [31:0] line);
        push_burst(owner, we, line);
        @(negedge clk_i);
        if (owner) begin
            i_req_i = 1'b1; i_addr_i = line;
        end else begin
            d_req_i = 1'b1; d_we_i = we; d_addr_i = line;
        end
        @(negedge clk_i);
        check_val("gnt_latency", 32'(mem_req_o), 32'd1);
        check_val("gnt_owner", 32'(gnt_o), owner ? 32'd2 : 32'd1);
    endtask

    task automatic wait_done(input bit owner);
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk_i);
            if (owner ? i_done_o : d_done_o) seen = 1'b1;
        end
        check_val("done_seen", 32'(seen), 32'd1);
        if (owner) i_req_i = 1'b0; else d_req_i = 1'b0;
    endtask

    task automatic tie_pair(input logic [31:0] dline, input logic [31:0] iline);
        push_burst(1'b0, 1'b0, dline);
        push_burst(1'b1, 1'b0, iline);
        @(negedge clk_i);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = dline;
        i_req_i = 1'b1; i_addr_i = iline;
        @(negedge clk_i);
        check_val("tie_gnt_d", 32'(gnt_o), 32'd1);
        wait_done(1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("tie_gnt_i", 32'(gnt_o), 32'd2);
        check_val("tie_req_i", 32'(mem_req_o), 32'd1);
        wait_done(1'b1);
    endtask

    task automatic check_all_zero();
        check_val("z_gnt", 32'(gnt_o), 0);
        check_val("z_beat", 32'(beat_o), 0);
        check_val("z_rdata", rdata_o, 0);
        check_val("z_rvalid", {30'b0, d_rvalid_o, i_rvalid_o}, 0);
        check_val("z_rbeat", 32'(rbeat_o), 0);
        check_val("z_done", {30'b0, d_done_o, i_done_o}, 0);
        check_val("z_memreq", {30'b0, mem_req_o, mem_we_o}, 0);
        check_val("z_memaddr", mem_addr_o, 0);
        check_val("z_memwdata", mem_wdata_o, 0);
    endtask

    // Monitor: drives the memory ack and scores every DUT output event.
    initial begin
        mem_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (rst_n_i) begin
                if (mem_req_o && mem_ack_i) begin
                    if (exp_acc.size() == 0) begin
                        check_val("acc_unexpected", 32'd1, 32'd0);
                    end else begin
                        acc_t a;
                        a = exp_acc.pop_front();
                        check_val("mem_addr", mem_addr_o, a.addr);
                        check_val("mem_we", 32'(mem_we_o), 32'(a.we));
                        check_val("mem_wdata", mem_wdata_o, a.wdata);
                    end
                end
                if (!mem_req_o) begin
                    check_val("idle_beat", 32'(beat_o), 0);
                    check_val("idle_we", 32'(mem_we_o), 0);
                end
                if (d_rvalid_o || i_rvalid_o) begin
                    check_val("rv_onehot", 32'(d_rvalid_o & i_rvalid_o), 0);
                    if (exp_rd.size() == 0) begin
                        check_val("rv_unexpected", 32'd1, 32'd0);
                    end else begin
                        rd_t r;
                        r = exp_rd.pop_front();
                        check_val("rv_owner", 32'(i_rvalid_o), 32'(r.owner));
                        check_val("rdata", rdata_o, r.data);
                        check_val("rbeat", 32'(rbeat_o), 32'(r.beat));
                    end
                end
                if (d_done_o || i_done_o) begin
                    if (exp_done.size() == 0) begin
                        check_val("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        done_t e;
                        e = exp_done.pop_front();
                        check_val("done_owner", {30'b0, i_done_o, d_done_o}, e.owner ? 32'd2 : 32'd1);
                        if (!e.we) begin
                            check_val("last_rvalid", 32'(e.owner ? i_rvalid_o : d_rvalid_o), 32'd1);
                            check_val("last_rbeat", 32'(rbeat_o), LW - 1);
                        end
                        n_txn++;
                        $display("txn %0d: %s %s burst complete", n_txn,
                                 e.owner ? "I" : "D", e.we ? "writeback" : "fill");
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0;
        i_req_i = 1'b0; i_addr_i = '0;
        repeat (3) @(negedge clk_i);
        check_all_zero();
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        check_all_zero();

        // Ties straight after reset: D, then I, then D again.
        tie_pair(32'h0000_3000, 32'h0000_4000);
        tie_pair(32'h0000_5000, 32'h0000_6000);

        // D fill, ack every cycle.
        start_burst(1'b0, 1'b0, 32'h0000_1000);
        wait_done(1'b0);

        // D writeback at an unaligned address with ack gaps.
        ack_mode = 1;
        start_burst(1'b0, 1'b1, 32'h0000_2004);
        wait_done(1'b0);
        d_we_i = 1'b0;

        // I fill: drop req and change address mid-burst.
        start_burst(1'b1, 1'b0, 32'h0000_7008);
        for (int c = 0; c < 100 && exp_acc.size() > 2; c++) begin
            @(negedge clk_i); #2;
        end
        i_req_i = 1'b0;
        i_addr_i = 32'h0000_FFF0;
        wait_done(1'b1);

        // Acks while idle must not move the beat or raise rvalid.
        ack_mode = 0;
        repeat (3) @(negedge clk_i);
        check_val("idle_ack_beat", 32'(beat_o), 0);
        check_val("idle_ack_rv", {30'b0, d_rvalid_o, i_rvalid_o}, 0);

        // Reset in the middle of a burst, then a fresh burst from beat 0.
        start_burst(1'b0, 1'b0, 32'h0000_1010);
        for (int c = 0; c < 100 && beat_o != 2'd2; c++) begin
            @(negedge clk_i); #2;
        end
        check_val("pre_rst_beat", 32'(beat_o), 32'd2);
        rst_n_i = 1'b0;
        #1;
        check_all_zero();
        exp_acc.delete();
        exp_rd.delete();
        exp_done.delete();
        d_req_i = 1'b0;
        @(negedge clk_i); #2;
        rst_n_i = 1'b1;
        start_burst(1'b0, 1'b0, 32'h0000_1030);
        wait_done(1'b0);

        repeat (4) @(negedge clk_i);
        check_val("sb_empty", 32'(exp_acc.size() + exp_rd.size() + exp_done.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
